// File: rtl/ex_mul4_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_mul4_unit_if
// Brief    : Bus bundle between the EX stage and the iterative MUL unit.
//            Carries the launch/flush controls, the operands, and the
//            result/done/busy/stall outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface ex_mul4_unit_if #(
  parameter int DATA_W = 32
);
  logic              start_i;
  logic              flush_i;
  logic [DATA_W-1:0] op_a_i;
  logic [DATA_W-1:0] op_b_i;
  logic [DATA_W-1:0] result_o;
  logic              done_o;
  logic              busy_o;
  logic              stall_o;

  // EX stage side: drives the request, observes the result
  modport master (
    output start_i, flush_i, op_a_i, op_b_i,
    input  result_o, done_o, busy_o, stall_o
  );

  // Multiplier side
  modport slave (
    input  start_i, flush_i, op_a_i, op_b_i,
    output result_o, done_o, busy_o, stall_o
  );
endinterface
`default_nettype wire

// File: rtl/ex_mul4_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_mul4_unit
// Brief    : Iterative 4-step 32-bit multiplier (low word of the product).
//            Consumes 8 bits of the multiplier per cycle.
//            Stalls the pipeline from launch until the cycle before done.
// Revision : 1.0 - initial release
// ============================================================================
module ex_mul4_unit #(
  parameter int DATA_W = 32
) (
  input  wire logic     clk,
  input  wire logic     arst_n,
  ex_mul4_unit_if.slave bus
);

  localparam int STEP_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [1:0]        cnt_q, cnt_d;

  logic [4:0]        shamt;
  logic [STEP_W-1:0] b_chunk;
  logic [DATA_W-1:0] partial;
  logic [DATA_W-1:0] acc_sum;
  logic              done_c;
  logic              stall_c;

  // Partial product for the current byte of B, aligned to its byte position
  always_comb begin
    shamt   = {cnt_q, 3'b000};
    b_chunk = b_q[shamt +: STEP_W];
    partial = (a_q * {{(DATA_W-STEP_W){1'b0}}, b_chunk}) << shamt;
    acc_sum = acc_q + partial;
  end

  // Next-state, datapath updates and handshake outputs; flush overrides all
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    done_c   = 1'b0;
    stall_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          a_d     = bus.op_a_i;
          b_d     = bus.op_b_i;
          acc_d   = '0;
          cnt_d   = 2'd0;
          state_d = ST_CALC;
          stall_c = 1'b1;
        end
      end
      ST_CALC: begin
        stall_c = 1'b1;
        acc_d   = acc_sum;
        cnt_d   = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          result_d = acc_sum;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        // The stalled instruction leaves EX on this edge; start_i is stale
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A killed instruction must neither complete nor hold the pipeline
    if (bus.flush_i) begin
      state_d  = ST_IDLE;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      done_c   = 1'b0;
      stall_c  = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.done_o   = done_c;
  assign bus.stall_o  = stall_c;
  assign bus.busy_o   = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ex_mul4_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mul4_unit
// Brief    : Self-checking bench for ex_mul4_unit: directed scenarios with
//            literal expectations plus randomized traffic against a
//            launch-latency reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mul4_unit;

  logic clk;
  logic arst_n;
  logic chk_en;
  int   checks;
  int   errors;

  ex_mul4_unit_if #(.DATA_W(32)) bus ();

  ex_mul4_unit #(.DATA_W(32)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: cycles elapsed since launch (-1 when nothing in flight).
  // A launch completes 5 cycles later; the product is plain 32-bit arithmetic.
  int          el   = -1;
  logic [31:0] pend = '0;
  logic [31:0] mres = '0;

  always @(posedge clk) begin
    if (!arst_n) begin
      el   = -1;
      mres = '0;
    end else if (bus.flush_i) begin
      el = -1;
    end else if (el == -1) begin
      if (bus.start_i) begin
        el   = 1;
        pend = bus.op_a_i * bus.op_b_i;
      end
    end else if (el == 4) begin
      el   = 5;
      mres = pend;
    end else if (el == 5) begin
      el = -1;
    end else begin
      el = el + 1;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    logic e_done, e_busy, e_stall;
    if (chk_en) begin
      e_busy  = (el != -1);
      e_done  = (el == 5) && !bus.flush_i;
      e_stall = !bus.flush_i && ((el == -1 && bus.start_i) || (el >= 1 && el <= 4));
      chk("cyc_result", bus.result_o, mres);
      chk("cyc_done",  {31'b0, bus.done_o},  {31'b0, e_done});
      chk("cyc_busy",  {31'b0, bus.busy_o},  {31'b0, e_busy});
      chk("cyc_stall", {31'b0, bus.stall_o}, {31'b0, e_stall});
    end
  end

  // Launch a MUL at the next cycle and hold start until done appears
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string nm,
                         input bit scramble, input bit glitch);
    int n;
    bit got;
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.flush_i = 1'b0;
    bus.op_a_i  = a;
    bus.op_b_i  = b;
    n   = 0;
    got = 1'b0;
    while (n < 20 && !got) begin
      @(negedge clk);
      if (bus.done_o) begin
        got = 1'b1;
      end else begin
        n++;
        if (scramble && n >= 2) begin
          bus.op_a_i = $urandom;
          bus.op_b_i = $urandom;
        end
        if (glitch && n == 2) begin
          #1 arst_n = 1'b0;
          #2 arst_n = 1'b1;
        end
      end
    end
    chk({nm, "_latency"}, n, 32'd5);
    chk({nm, "_result"}, bus.result_o, exp);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    chk_en      = 1'b0;
    arst_n      = 1'b0;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.op_a_i  = '0;
    bus.op_b_i  = '0;

    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    arst_n = 1'b1;
    @(negedge clk);
    chk("rst_result", bus.result_o, 32'h0);
    chk("rst_busy",   {31'b0, bus.busy_o},  32'h0);
    chk("rst_stall",  {31'b0, bus.stall_o}, 32'h0);
    chk("rst_done",   {31'b0, bus.done_o},  32'h0);

    // Basic and wraparound products
    run_mul(32'd3, 32'd5, 32'h0000000F, "basic", 1'b0, 1'b0);
    go_idle();
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "wrap_ff", 1'b0, 1'b0);
    go_idle();
    run_mul(32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFD6, "wrap_neg", 1'b0, 1'b0);
    go_idle();
    run_mul(32'h00010000, 32'h00010000, 32'h00000000, "wrap_zero", 1'b0, 1'b0);
    go_idle();

    // Operands changing during CALC must not matter
    run_mul(32'h12345678, 32'h00000100, 32'h34567800, "indep", 1'b1, 1'b0);
    go_idle();

    // Back-to-back: second request presented the cycle after DONE
    run_mul(32'd2, 32'd3, 32'h6, "b2b_first", 1'b0, 1'b0);
    run_mul(32'h100, 32'h100, 32'h10000, "b2b_second", 1'b0, 1'b0);
    go_idle();

    // Flush at cycle 2 of a launch, fresh launch at cycle 4
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.op_a_i  = 32'h55;
    bus.op_b_i  = 32'h3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.flush_i = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    chk("flush_stall", {31'b0, bus.stall_o}, 32'h0);
    chk("flush_done",  {31'b0, bus.done_o},  32'h0);
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    @(negedge clk);
    chk("flush_idle",   {31'b0, bus.busy_o}, 32'h0);
    chk("flush_result", bus.result_o, 32'h10000);
    run_mul(32'd7, 32'd9, 32'd63, "post_flush", 1'b0, 1'b0);
    go_idle();

    // Reset asserted at cycle 3 of a launch
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.op_a_i  = 32'h1234;
    bus.op_b_i  = 32'h10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    arst_n      = 1'b0;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    arst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_result", bus.result_o, 32'h0);
    chk("rstmid_busy",   {31'b0, bus.busy_o},  32'h0);
    chk("rstmid_done",   {31'b0, bus.done_o},  32'h0);
    chk("rstmid_stall",  {31'b0, bus.stall_o}, 32'h0);

    // A reset pulse between edges is never sampled
    run_mul(32'h00000101, 32'h01010101, 32'h02020201, "glitch", 1'b0, 1'b1);
    go_idle();

    // Randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      bus.start_i = ($urandom % 4) != 0;
      bus.flush_i = ($urandom % 16) == 0;
      arst_n      = ($urandom % 64) != 0;
      bus.op_a_i  = (($urandom % 5) == 0) ? 32'hFFFFFFFF : $urandom;
      bus.op_b_i  = (($urandom % 5) == 0) ? 32'hFFFFFFFF : $urandom;
    end
    @(posedge clk); #1;
    arst_n      = 1'b1;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
